// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: debounced keypad front end and operand/operator sequencer for an external ALU
module calc_key_sequencer #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int EXEC_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] swp,
   input  logic [7:0]  swd,
   input  logic        alu_done,
   input  logic        alu_err,
   input  logic [15:0] alu_result,
   output logic        alu_start,
   output logic [13:0] alu_a,
   output logic [13:0] alu_b,
   output logic [1:0]  alu_op,
   output logic [15:0] disp_val,
   output logic        disp_sgn,
   output logic [2:0]  state,
   output logic        err
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int TW = $clog2(EXEC_TIMEOUT + 1);
   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      EXEC    = 3'd2,
      SHOW    = 3'd3,
      ERROR   = 3'd4
   } state_t;
   state_t        state_q, state_d;
   logic [15:0]   cand_q, cand_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          armed_q, armed_d;
   logic [13:0]   entry_q, entry_d;
   logic [2:0]    dcnt_q, dcnt_d;
   logic [13:0]   alu_a_q, alu_a_d;
   logic [13:0]   alu_b_q, alu_b_d;
   logic [1:0]    alu_op_q, alu_op_d;
   logic [15:0]   res_q, res_d;
   logic          start_q, start_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [15:0]   kv;
   logic          accept, onehot, ev;
   logic          is_clr, is_equ, is_op, is_dig, dig_ok, res_ok;
   logic [1:0]    key_op;
   logic [3:0]    dig;
   logic          unused_keys;
   assign unused_keys = ^{swp[1:0], swd[7:6]};
   assign kv     = {swp[11:2], swd[5:0]};
   assign accept = (kv == cand_q) && (db_cnt_q == DW'(DEBOUNCE_CYC - 1));
   assign onehot = (cand_q != 16'd0) && ((cand_q & (cand_q - 16'd1)) == 16'd0);
   assign ev     = accept && armed_q && onehot;
   assign is_clr = ev && cand_q[1];
   assign is_equ = ev && cand_q[0];
   assign is_op  = ev && (|cand_q[5:2]);
   assign is_dig = ev && (|cand_q[15:6]);
   assign key_op = {cand_q[3] | cand_q[2], cand_q[4] | cand_q[2]};
   assign dig_ok = (dcnt_q < 3'd4) && ((entry_q != 14'd0) || (dig != 4'd0));
   assign res_ok = !res_q[15] && (res_q <= 16'd9999);
   // Debounce: a vector is accepted once it has been seen unchanged long enough; events need a prior all-zero accept
   always_comb begin
      cand_d   = kv;
      db_cnt_d = (kv != cand_q) ? '0 : (db_cnt_q == DW'(DEBOUNCE_CYC)) ? db_cnt_q : db_cnt_q + DW'(1);
      armed_d  = accept ? (cand_q == 16'd0) : armed_q;
   end
   // Digit value of the one-hot keypad bit; bit 6 is digit 0, bits 15..7 are digits 1..9
   always_comb begin
      dig = 4'd0;
      for (int i = 7; i < 16; i++)
         if (cand_q[i]) dig = 4'(16 - i);
   end
   // Sequencer next-state: key handling per state, ALU completion/timeout, CLR overrides everything
   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      dcnt_d   = dcnt_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      res_d    = res_q;
      start_d  = 1'b0;
      tmo_d    = tmo_q;
      case (state_q)
         ENTER_A: begin
            if (is_dig && dig_ok) begin
               entry_d = entry_q * 14'd10 + {10'd0, dig};
               dcnt_d  = dcnt_q + 3'd1;
            end else if (is_op) begin
               alu_a_d  = entry_q;
               alu_op_d = key_op;
               entry_d  = 14'd0;
               dcnt_d   = 3'd0;
               state_d  = ENTER_B;
            end
         end
         ENTER_B: begin
            if (is_dig && dig_ok) begin
               entry_d = entry_q * 14'd10 + {10'd0, dig};
               dcnt_d  = dcnt_q + 3'd1;
            end else if (is_op && dcnt_q == 3'd0) begin
               alu_op_d = key_op;
            end else if (is_equ) begin
               alu_b_d = entry_q;
               entry_d = 14'd0;
               dcnt_d  = 3'd0;
               start_d = 1'b1;
               tmo_d   = '0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (alu_done) begin
               res_d   = alu_err ? res_q : alu_result;
               state_d = alu_err ? ERROR : SHOW;
            end else if (tmo_q == TW'(EXEC_TIMEOUT - 1)) begin
               state_d = ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         SHOW: begin
            if (is_dig) begin
               entry_d = {10'd0, dig};
               dcnt_d  = (dig != 4'd0) ? 3'd1 : 3'd0;
               state_d = ENTER_A;
            end else if (is_op && res_ok) begin
               alu_a_d  = res_q[13:0];
               alu_op_d = key_op;
               entry_d  = 14'd0;
               dcnt_d   = 3'd0;
               state_d  = ENTER_B;
            end
         end
         ERROR:   state_d = ERROR;
         default: state_d = ENTER_A;
      endcase
      if (is_clr) begin
         state_d  = ENTER_A;
         entry_d  = 14'd0;
         dcnt_d   = 3'd0;
         alu_a_d  = 14'd0;
         alu_b_d  = 14'd0;
         alu_op_d = 2'd0;
         res_d    = 16'd0;
         start_d  = 1'b0;
         tmo_d    = '0;
      end
   end
   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ENTER_A;
         cand_q   <= 16'd0;
         db_cnt_q <= '0;
         armed_q  <= 1'b0;
         entry_q  <= 14'd0;
         dcnt_q   <= 3'd0;
         alu_a_q  <= 14'd0;
         alu_b_q  <= 14'd0;
         alu_op_q <= 2'd0;
         res_q    <= 16'd0;
         start_q  <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         db_cnt_q <= db_cnt_d;
         armed_q  <= armed_d;
         entry_q  <= entry_d;
         dcnt_q   <= dcnt_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         res_q    <= res_d;
         start_q  <= start_d;
         tmo_q    <= tmo_d;
      end
   end
   assign alu_start = start_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign state     = state_q;
   assign err       = (state_q == ERROR);
   assign disp_sgn  = (state_q == SHOW);
   assign disp_val  = (state_q == ENTER_A || state_q == ENTER_B) ? {2'd0, entry_q} :
                      (state_q == EXEC) ? {2'd0, alu_a_q} :
                      (state_q == SHOW) ? res_q : 16'd0;
endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 4, cycles a key vector must be stable before it is accepted.
REQ-002 SHALL have parameter EXEC_TIMEOUT, default 255, cycles allowed in EXEC for alu_done.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 swp  in  12  keypad; swp[11:3] = digits 1..9, swp[2] = digit 0, swp[1:0] ignored.
REQ-006 swd  in  8  function keys; [5] ADD, [4] SUB, [3] MUL, [2] DIV, [1] CLR, [0] EQU; [7:6] ignored.
REQ-007 alu_done  in  1  one-cycle pulse, ALU result valid.
REQ-008 alu_err  in  1  qualified by alu_done; ALU error, e.g. divide by zero.
REQ-009 alu_result  in  16  signed two's-complement result, qualified by alu_done.
REQ-010 alu_start  out  1  one-cycle pulse launching the operation.
REQ-011 alu_a, alu_b  out  14 each  unsigned operands, stable from alu_start until leaving EXEC.
REQ-012 alu_op  out  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-013 disp_val  out  16  value to display; disp_sgn out 1, set when disp_val is a signed result.
REQ-014 state  out  3  000 ENTER_A, 001 ENTER_B, 010 EXEC, 011 SHOW, 100 ERROR.
REQ-015 err  out  1  high exactly while state = ERROR.

Function
REQ-016 Key vector = {swp[11:2], swd[5:0]}; a new vector SHALL be accepted only after it has been unchanged for DEBOUNCE_CYC consecutive cycles.
REQ-017 A key event SHALL fire once, on the cycle the accepted vector changes from all-zero to exactly one-hot; multi-hot vectors produce no event; the next event requires a return to all-zero.
REQ-018 Digit in ENTER_A/ENTER_B: entry = entry*10 + d, digit count +1, only if count < 4; a 5th digit is ignored; 0 while entry = 0 leaves count at 0.
REQ-019 Operator in ENTER_A: alu_a <= entry, alu_op <= key, entry and count cleared, state -> ENTER_B.
REQ-020 Operator in ENTER_B: count = 0 replaces alu_op; count > 0 is ignored.
REQ-021 EQU in ENTER_B: alu_b <= entry (0 if no digits), alu_start pulses on the following cycle, state -> EXEC; EQU in ENTER_A is ignored.
REQ-022 EXEC: all keys except CLR ignored; alu_done with alu_err = 0 latches result, state -> SHOW; alu_done with alu_err = 1 -> ERROR; EXEC_TIMEOUT cycles without alu_done -> ERROR.
REQ-023 SHOW: digit clears entry, applies digit, state -> ENTER_A; operator with result in 0..9999 sets alu_a <= result and alu_op, state -> ENTER_B; operator with any other result is ignored; EQU is ignored.
REQ-024 ERROR: only CLR is accepted.
REQ-025 CLR in any state clears entry, count, operands, alu_op and result, state -> ENTER_A; CLR in EXEC abandons the operation, and a later alu_done is ignored.
REQ-026 disp_val = entry in ENTER_A/ENTER_B, alu_a in EXEC, result in SHOW, 0 in ERROR; disp_sgn = 1 only in SHOW.
REQ-027 alu_done outside EXEC SHALL be ignored; alu_start SHALL never be high in two consecutive cycles.

Reset
REQ-028 While rst = 0: state = ENTER_A; alu_start, err, disp_sgn = 0; alu_a, alu_b, alu_op, disp_val = 0; debounce and timeout counters cleared.
REQ-029 Reset SHALL act immediately and asynchronously, including mid-debounce and in EXEC.
REQ-030 After release, a key already held SHALL produce no event until the vector returns to all-zero.

Verification
REQ-031 Keys 2,3, ADD, 4,5,6, EQU; alu_done with result 479 -> alu_a = 23, alu_b = 456, alu_op = 00, one alu_start pulse, state SHOW, disp_val = 479.
REQ-032 Keys 1,2,3,4,5 -> disp_val = 1234; key 0 from reset -> disp_val 0, count 0; then 7 -> 7.
REQ-033 Key pulse shorter than DEBOUNCE_CYC -> no change; swp[10] and swd[5] held together -> no event.
REQ-034 Keys 8, DIV, 0, EQU; alu_done with alu_err = 1 -> state ERROR, err = 1, disp_val 0; digits ignored; CLR -> ENTER_A.
REQ-035 EQU with no alu_done for EXEC_TIMEOUT cycles -> ERROR; CLR in EXEC followed by a late alu_done -> ENTER_A unchanged.
REQ-036 From SHOW with result 479, key SUB, 9, EQU -> alu_a = 479, alu_b = 9, alu_op = 01; with result -5, key SUB is ignored and state stays SHOW.
